// File: rtl/mem_read_pkg.sv
// Shared load/store definitions: one-hot access-size encoding, the cs lane
// select helpers, and the result payload carried through the load buffer.
package mem_read_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MODE_W = 3;
  localparam int unsigned CS_W   = 2;

  localparam logic [MODE_W-1:0] MODE_BYTE = 3'b001;
  localparam logic [MODE_W-1:0] MODE_HALF = 3'b010;
  localparam logic [MODE_W-1:0] MODE_WORD = 3'b100;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } ld_rsp_t;

  // Byte lane addressed by cs: cs=0 is bits [7:0], cs=3 is bits [31:24].
  function automatic logic [7:0] lane_byte(input logic [DATA_W-1:0] word,
                                           input logic [CS_W-1:0]   cs);
    logic [7:0] lane;
    case (cs)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      default: lane = word[31:24];
    endcase
    return lane;
  endfunction

  // Half lane selected by cs[1].
  function automatic logic [15:0] lane_half(input logic [DATA_W-1:0] word,
                                            input logic              hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/mem_read_if.sv
// Load-path bus: MEM-stage request, data SRAM read port, WB-stage response.
// slave  : the load unit (accepts requests, drives SRAM enable and responses)
// master : the surrounding pipeline / SRAM (drives requests, rdata, rsp_ready)
interface mem_read_if #(
  parameter int unsigned TAG_W = 5
);
  import mem_read_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [MODE_W-1:0]   req_mode;
  logic [CS_W-1:0]     req_cs;
  logic                req_unsigned;
  logic [TAG_W-1:0]    req_tag;
  logic                data_sram_en;
  logic [DATA_W-1:0]   data_sram_rdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic [TAG_W-1:0]    rsp_tag;

  modport slave (
    input  req_valid, req_mode, req_cs, req_unsigned, req_tag,
    input  data_sram_rdata, rsp_ready,
    output req_ready, data_sram_en, rsp_valid, rsp_data, rsp_err, rsp_tag
  );

  modport master (
    output req_valid, req_mode, req_cs, req_unsigned, req_tag,
    output data_sram_rdata, rsp_ready,
    input  req_ready, data_sram_en, rsp_valid, rsp_data, rsp_err, rsp_tag
  );

endinterface

// File: rtl/mem_read_load_align.sv
// Combinational load formatter: picks the byte/half/word lane from the SRAM
// word and sign- or zero-extends it; flags misaligned or non-one-hot modes.
// Ports: rdata_i (SRAM word), mode_i (one-hot size), cs_i (addr[1:0]),
//        unsigned_i (1 = zero-extend), data_o (result), err_o (fault flag).
module mem_read_load_align
  import mem_read_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [CS_W-1:0]   cs_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = lane_byte(rdata_i, cs_i);
  assign half_lane = lane_half(rdata_i, cs_i[1]);

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (mode_i)
      MODE_BYTE: data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
      MODE_HALF: begin
        if (cs_i[0]) err_o  = 1'b1;
        else         data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
      end
      MODE_WORD: begin
        if (cs_i != 2'b00) err_o  = 1'b1;
        else               data_o = rdata_i;
      end
      default:   err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_read.sv
// Load unit between MEM and WB: issues the SRAM read, formats the returned
// word one cycle later, and buffers results in out + skid so a WB stall
// never drops SRAM data.
// Ports: clk, reset (async, active-high), bus (mem_read_if.slave): request
//        handshake, SRAM enable/rdata, response handshake with data/err/tag.
module mem_read
  import mem_read_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  mem_read_if.slave   bus
);

  // Request captured at acceptance, formatted when its SRAM word returns.
  logic              pend_valid_q, pend_valid_d;
  logic [MODE_W-1:0] pend_mode_q,  pend_mode_d;
  logic [CS_W-1:0]   pend_cs_q,    pend_cs_d;
  logic              pend_uns_q,   pend_uns_d;
  logic [TAG_W-1:0]  pend_tag_q,   pend_tag_d;

  logic              out_valid_q,  out_valid_d;
  ld_rsp_t           out_q,        out_d;
  logic [TAG_W-1:0]  out_tag_q,    out_tag_d;

  logic              skid_valid_q, skid_valid_d;
  ld_rsp_t           skid_q,       skid_d;
  logic [TAG_W-1:0]  skid_tag_q,   skid_tag_d;

  ld_rsp_t           fmt;
  logic              out_free;
  logic              sram_en;

  mem_read_load_align u_align (
    .rdata_i    (bus.data_sram_rdata),
    .mode_i     (pend_mode_q),
    .cs_i       (pend_cs_q),
    .unsigned_i (pend_uns_q),
    .data_o     (fmt.data),
    .err_o      (fmt.err)
  );

  // Accept only when every in-flight read has a slot to land in. A pending
  // read with out occupied is fine if out drains this cycle, which keeps
  // one-load-per-cycle streaming while rsp_ready is high.
  assign out_free      = !out_valid_q || bus.rsp_ready;
  assign bus.req_ready = !reset && !skid_valid_q
                         && !(pend_valid_q && out_valid_q && !bus.rsp_ready);
  assign sram_en          = bus.req_valid && bus.req_ready;
  assign bus.data_sram_en = sram_en;

  assign bus.rsp_valid = out_valid_q;
  assign bus.rsp_data  = out_q.data;
  assign bus.rsp_err   = out_q.err;
  assign bus.rsp_tag   = out_tag_q;

  // Next-state: out drains skid first (older), then the freshly formatted read.
  always_comb begin
    pend_valid_d = sram_en;
    pend_mode_d  = pend_mode_q;
    pend_cs_d    = pend_cs_q;
    pend_uns_d   = pend_uns_q;
    pend_tag_d   = pend_tag_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    skid_tag_d   = skid_tag_q;

    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_d        = skid_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        out_valid_d = 1'b1;
        out_d       = fmt;
        out_tag_d   = pend_tag_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (pend_valid_q) begin
      skid_valid_d = 1'b1;
      skid_d       = fmt;
      skid_tag_d   = pend_tag_q;
    end

    if (sram_en) begin
      pend_mode_d = bus.req_mode;
      pend_cs_d   = bus.req_cs;
      pend_uns_d  = bus.req_unsigned;
      pend_tag_d  = bus.req_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_mode_q  <= '0;
      pend_cs_q    <= '0;
      pend_uns_q   <= 1'b0;
      pend_tag_q   <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_tag_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      pend_cs_q    <= pend_cs_d;
      pend_uns_q   <= pend_uns_d;
      pend_tag_q   <= pend_tag_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

endmodule
